// File: rtl/apb_master_ctrl.sv
// APB requester: valid/ready command -> SETUP/ACCESS, 3-cycle accept-to-response latency, no rsp backpressure.
// Build option APB_PREADY_EN adds Pready wait states; cmd_ready holds low until the ACCESS phase completes.
module apb_master_ctrl #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                NSLV     = 4,
   parameter logic [ADDR_W-1:0] BASE     = ADDR_W'(32'h8000_0000),
   parameter logic [ADDR_W-1:0] SLV_SPAN = ADDR_W'(32'h0400_0000)
) (
   input  logic              clock,
   input  logic              Hresetn,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic              cmd_write,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] Paddr,
   output logic              Pwrite,
   output logic [DATA_W-1:0] Pwdata,
   output logic [NSLV-1:0]   Pselx,
   output logic              Penable,
   input  logic [DATA_W-1:0] Prdata
`ifdef APB_PREADY_EN
   ,input logic              Pready
`endif
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

   state_t            state, nxt;
   logic              access_fin;
   logic              accept;
   logic              rsp_hit_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] dec_off;
   logic [ADDR_W-1:0] dec_idx;
   logic              dec_hit;
   logic [NSLV-1:0]   dec_sel;

`ifdef APB_PREADY_EN
   assign access_fin = (state == ACCESS) && Pready;
`else
   assign access_fin = (state == ACCESS);
`endif

   assign accept = cmd_valid && cmd_ready;

   always_comb begin
      dec_off = cmd_addr - BASE;
      dec_idx = dec_off / SLV_SPAN;
      dec_hit = (cmd_addr >= BASE) && (dec_idx < ADDR_W'(NSLV));
      dec_sel = '0;
      for (int i = 0; i < NSLV; i++) begin
         dec_sel[i] = dec_hit && (dec_idx == ADDR_W'(i));
      end
   end

   always_ff @(posedge clock) begin
      if (!Hresetn) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   // A miss accepted on the final ACCESS edge lands in ERR while the previous
   // hit response is still due; ERR waits one cycle so responses never collide.
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (accept) nxt = dec_hit ? SETUP : ERR;
         SETUP:   nxt = ACCESS;
         ACCESS:  if (access_fin) nxt = accept ? (dec_hit ? SETUP : ERR) : IDLE;
         ERR:     if (!rsp_hit_q) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      rsp_valid = rsp_hit_q;
      rsp_err   = 1'b0;
      rsp_rdata = rsp_hit_q ? rdata_q : '0;
      case (state)
         IDLE:    cmd_ready = Hresetn;
         ACCESS:  cmd_ready = Hresetn && access_fin;
         ERR: begin
            if (!rsp_hit_q) begin
               rsp_valid = 1'b1;
               rsp_err   = 1'b1;
            end
         end
         default: cmd_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!Hresetn) begin
         Paddr     <= '0;
         Pwrite    <= 1'b0;
         Pwdata    <= '0;
         Pselx     <= '0;
         Penable   <= 1'b0;
         rsp_hit_q <= 1'b0;
         rdata_q   <= '0;
      end else begin
         rsp_hit_q <= access_fin;
         if (access_fin) begin
            rdata_q <= Pwrite ? '0 : Prdata;
         end
         if (accept && dec_hit) begin
            Paddr   <= cmd_addr;
            Pwrite  <= cmd_write;
            Pselx   <= dec_sel;
            Penable <= 1'b0;
            if (cmd_write) begin
               Pwdata <= cmd_wdata;
            end
         end else if (state == SETUP) begin
            Penable <= 1'b1;
         end else if (access_fin) begin
            Pselx   <= '0;
            Penable <= 1'b0;
         end
      end
   end

endmodule
